// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM state encoding for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way grant picker; MEM_ARB_RR_EN selects round-robin,
// otherwise fixed priority with req0 winning.
module mem_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt
);

`ifdef MEM_ARB_RR_EN
    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        gnt = req1;
        if (req0 && req1) begin
            gnt = ~last;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt = req1 & ~req0;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wen0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              m_cen,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout
);

    state_t            state;
    state_t            nstate;
    logic              gnt;
    logic              last;
    logic              sel_wen;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              oor;
    logic              w_id;
    logic              w_wen;
    logic              w_err;

    mem_arb_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .gnt  (gnt)
    );

`ifdef MEM_ARB_RR_EN
    // Reset value 1 means requester 0 is favoured first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state == IDLE && (req0 || req1)) begin
            last <= gnt;
        end
    end
`else
    assign last = 1'b1;
`endif

    always_comb begin
        sel_wen   = gnt ? wen1   : wen0;
        sel_addr  = gnt ? addr1  : addr0;
        sel_wdata = gnt ? wdata1 : wdata0;
        oor       = (sel_addr >= ADDR_W'(MEM_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (req0 || req1) nstate = ISSUE;
            ISSUE:   nstate = WAIT;
            WAIT:    nstate = ACK;
            ACK:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_id   <= 1'b0;
            w_wen  <= 1'b0;
            w_err  <= 1'b0;
            m_cen  <= 1'b0;
            m_wen  <= 1'b0;
            m_addr <= '0;
            m_din  <= '0;
            rdata  <= '0;
            err    <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        w_id  <= gnt;
                        w_wen <= sel_wen;
                        w_err <= oor;
                        if (!oor) begin
                            m_cen  <= 1'b1;
                            m_wen  <= sel_wen;
                            m_addr <= sel_addr;
                            m_din  <= sel_wdata;
                        end
                    end
                end
                ISSUE: begin
                    m_cen <= 1'b0;
                    m_wen <= 1'b0;
                end
                WAIT: begin
                    // The memory's registered read data is valid one cycle after it sampled cen.
                    rdata <= (!w_wen && !w_err) ? m_dout : '0;
                    err   <= w_err;
                    ack0  <= ~w_id;
                    ack1  <= w_id;
                end
                ACK: begin
                    rdata <= '0;
                    err   <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 32x32 memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, wen0, wen1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, err, busy, m_cen, m_wen;
    logic [DATA_W-1:0] rdata, m_din, m_dout;
    logic [ADDR_W-1:0] m_addr;

    logic [31:0] mem [32];
    int nvec = 0;
    int nerr = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .m_cen(m_cen), .m_wen(m_wen), .m_addr(m_addr), .m_din(m_din),
        .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory with registered read data
    always @(posedge clk) begin
        if (m_cen) begin
            if (m_wen) mem[m_addr[4:0]] <= m_din;
            else       m_dout <= mem[m_addr[4:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0 = 0; req1 = 0; wen0 = 0; wen1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic wait_ack(output bit a0, output bit a1, output logic [31:0] rd,
                            output logic e, output bit cs, output int cyc);
        a0 = 0; a1 = 0; rd = '0; e = 0; cs = 0; cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (m_cen) cs = 1;
            if (ack0 || ack1) begin
                a0 = ack0; a1 = ack1; rd = rdata; e = err; cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1; idle_inputs;
        tick; tick;
        nvec++; if ({ack0, ack1, err, busy, m_cen, m_wen} !== 6'b0) begin nerr++; $display("FAIL rst_flags: got %b want 000000", {ack0, ack1, err, busy, m_cen, m_wen}); end
        nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        nvec++; if (m_addr !== 8'h0) begin nerr++; $display("FAIL rst_maddr: got %h want 0", m_addr); end
        nvec++; if (m_din !== 32'h0) begin nerr++; $display("FAIL rst_mdin: got %h want 0", m_din); end
        reset = 0;
        tick;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_read;
        req0 = 1; wen0 = 1; addr0 = 8'd5; wdata0 = 32'hDEADBEEF;
        tick;
        nvec++; if ({m_cen, m_wen} !== 2'b11) begin nerr++; $display("FAIL wr_cen_wen: got %b want 11", {m_cen, m_wen}); end
        nvec++; if (m_addr !== 8'd5) begin nerr++; $display("FAIL wr_maddr: got %h want 05", m_addr); end
        nvec++; if (m_din !== 32'hDEADBEEF) begin nerr++; $display("FAIL wr_mdin: got %h want deadbeef", m_din); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL wr_busy: got %b want 1", busy); end
        tick;
        nvec++; if ({m_cen, m_wen, ack0} !== 3'b000) begin nerr++; $display("FAIL wr_issue_end: got %b want 000", {m_cen, m_wen, ack0}); end
        tick;
        nvec++; if ({ack0, ack1, err} !== 3'b100) begin nerr++; $display("FAIL wr_ack: got %b want 100", {ack0, ack1, err}); end
        nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL wr_rdata: got %h want 0", rdata); end
        req0 = 0;
        tick;
        nvec++; if ({ack0, busy} !== 2'b00) begin nerr++; $display("FAIL wr_after: got %b want 00", {ack0, busy}); end
        req0 = 1; wen0 = 0;
        tick;
        nvec++; if ({m_cen, m_wen} !== 2'b10) begin nerr++; $display("FAIL rd_cen_wen: got %b want 10", {m_cen, m_wen}); end
        nvec++; if (m_addr !== 8'd5) begin nerr++; $display("FAIL rd_maddr: got %h want 05", m_addr); end
        tick;
        nvec++; if ({m_cen, ack0} !== 2'b00) begin nerr++; $display("FAIL rd_wait: got %b want 00", {m_cen, ack0}); end
        tick;
        nvec++; if ({ack0, ack1, err} !== 3'b100) begin nerr++; $display("FAIL rd_ack: got %b want 100", {ack0, ack1, err}); end
        nvec++; if (rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_rdata: got %h want deadbeef", rdata); end
        req0 = 0;
        tick;
        nvec++; if ({ack0, rdata} !== 33'h0) begin nerr++; $display("FAIL rd_after: got %b/%h want 0/0", ack0, rdata); end
    endtask

    task automatic test_out_of_range;
        bit a0, a1, cs; logic [31:0] rd; logic e; int cyc;
        req1 = 1; wen1 = 0; addr1 = 8'd40;
        wait_ack(a0, a1, rd, e, cs, cyc);
        nvec++; if ({a0, a1, e, cs} !== 4'b0110) begin nerr++; $display("FAIL oor40_flags: got a0a1 err cen %b want 0110", {a0, a1, e, cs}); end
        nvec++; if (rd !== 32'h0) begin nerr++; $display("FAIL oor40_rdata: got %h want 0", rd); end
        nvec++; if (cyc !== 3) begin nerr++; $display("FAIL oor40_lat: got %0d want 3", cyc); end
        req1 = 0;
        tick;
        nvec++; if ({err, ack1} !== 2'b00) begin nerr++; $display("FAIL oor40_clear: got %b want 00", {err, ack1}); end
        req1 = 1; wen1 = 1; addr1 = 8'd32; wdata1 = 32'hAAAA5555;
        wait_ack(a0, a1, rd, e, cs, cyc);
        nvec++; if ({a1, e, cs} !== 3'b110) begin nerr++; $display("FAIL oor32_flags: got ack1 err cen %b want 110", {a1, e, cs}); end
        req1 = 0;
        tick;
        nvec++; if (mem[0] === 32'hAAAA5555) begin nerr++; $display("FAIL oor32_mem: got %h want not aaaa5555", mem[0]); end
        req0 = 1; wen0 = 1; addr0 = 8'd31; wdata0 = 32'h0BADF00D;
        wait_ack(a0, a1, rd, e, cs, cyc);
        nvec++; if ({a0, e, cs} !== 3'b101) begin nerr++; $display("FAIL a31_flags: got ack0 err cen %b want 101", {a0, e, cs}); end
        req0 = 0;
        tick;
        nvec++; if (mem[31] !== 32'h0BADF00D) begin nerr++; $display("FAIL a31_mem: got %h want 0badf00d", mem[31]); end
    endtask

    task automatic test_sampling;
        bit a0, a1, cs; logic [31:0] rd; logic e; int cyc; int cnt;
        req0 = 1; wen0 = 1; addr0 = 8'd3; wdata0 = 32'h12345678;
        tick;
        wdata0 = 32'hFFFFFFFF; addr0 = 8'd4; wen0 = 0; req0 = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (ack0) cnt++;
        end
        nvec++; if (cnt !== 1) begin nerr++; $display("FAIL smp_acks: got %0d want 1", cnt); end
        nvec++; if (mem[3] !== 32'h12345678) begin nerr++; $display("FAIL smp_mem3: got %h want 12345678", mem[3]); end
        nvec++; if (mem[4] !== 32'h0) begin nerr++; $display("FAIL smp_mem4: got %h want 0", mem[4]); end
        req0 = 1; wen0 = 0; addr0 = 8'd3;
        wait_ack(a0, a1, rd, e, cs, cyc);
        nvec++; if (rd !== 32'h12345678) begin nerr++; $display("FAIL smp_readback: got %h want 12345678", rd); end
        req0 = 0;
        tick;
    endtask

    task automatic test_arbitration;
        bit a0, a1, cs; logic [31:0] rd; logic e; int cyc;
        bit exp1;
        reset = 1; tick; reset = 0; tick;
        req0 = 1; wen0 = 0; addr0 = 8'd5;
        req1 = 1; wen1 = 0; addr1 = 8'd31;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp1 = (k % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            wait_ack(a0, a1, rd, e, cs, cyc);
            nvec++; if ({a0, a1} !== {~exp1, exp1}) begin nerr++; $display("FAIL arb_winner%0d: got ack0ack1 %b want %b", k, {a0, a1}, {~exp1, exp1}); end
            nvec++; if (rd !== (exp1 ? 32'h0BADF00D : 32'hDEADBEEF)) begin nerr++; $display("FAIL arb_rdata%0d: got %h want %h", k, rd, exp1 ? 32'h0BADF00D : 32'hDEADBEEF); end
            nvec++; if (cyc !== ((k == 0) ? 3 : 4)) begin nerr++; $display("FAIL arb_gap%0d: got %0d want %0d", k, cyc, (k == 0) ? 3 : 4); end
        end
        req0 = 0; req1 = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        bit a0, a1, cs; logic [31:0] rd; logic e; int cyc; int cnt;
        req0 = 1; wen0 = 0; addr0 = 8'd5;
        tick; tick;
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
        reset = 1;
        #1;
        nvec++; if ({busy, ack0, ack1, err, m_cen, m_wen} !== 6'b0) begin nerr++; $display("FAIL rmid_async: got %b want 000000", {busy, ack0, ack1, err, m_cen, m_wen}); end
        nvec++; if ({rdata, m_din, m_addr} !== 72'h0) begin nerr++; $display("FAIL rmid_buses: got %h want 0", {rdata, m_din, m_addr}); end
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (ack0 || ack1) cnt++;
        end
        nvec++; if (cnt !== 0) begin nerr++; $display("FAIL rmid_noack: got %0d want 0", cnt); end
        req0 = 0; reset = 0;
        req1 = 1; wen1 = 0; addr1 = 8'd5;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy_post: got %b want 0", busy); end
        wait_ack(a0, a1, rd, e, cs, cyc);
        nvec++; if ({a0, a1, cs, e} !== 4'b0110) begin nerr++; $display("FAIL rmid_req1: got a0a1 cen err %b want 0110", {a0, a1, cs, e}); end
        nvec++; if (rd !== 32'hDEADBEEF || cyc !== 3) begin nerr++; $display("FAIL rmid_rd: got %h/%0d want deadbeef/3", rd, cyc); end
        req1 = 0;
        tick;
    endtask

    task automatic test_back_to_back;
        int acks, cens;
        int pos [3];
        acks = 0; cens = 0;
        pos[0] = 0; pos[1] = 0; pos[2] = 0;
        req0 = 1; wen0 = 0; addr0 = 8'd5;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (m_cen) cens++;
            if (ack0) begin
                if (acks < 3) pos[acks] = i;
                acks++;
            end
        end
        nvec++; if (acks !== 3) begin nerr++; $display("FAIL b2b_acks: got %0d want 3", acks); end
        nvec++; if (cens !== 3) begin nerr++; $display("FAIL b2b_cens: got %0d want 3", cens); end
        nvec++; if ({pos[0], pos[1], pos[2]} !== {32'd3, 32'd7, 32'd11}) begin nerr++; $display("FAIL b2b_pos: got %0d,%0d,%0d want 3,7,11", pos[0], pos[1], pos[2]); end
        req0 = 0;
        tick; tick;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        m_dout = '0;
        test_reset;
        test_write_read;
        test_out_of_range;
        test_sampling;
        test_arbitration;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
